// File: rtl/cond_ctl_pkg.sv
// cond_ctl_pkg: shared types for the conditional-sink control sequencer.
package cond_ctl_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, REQ, REL} state_e;
  localparam int SYNC_DEPTH = 2;
endpackage

// File: rtl/cond_ctl_sync.sv
// cond_ctl_sync: N-flop async-reset synchronizer for a single-bit level.
module cond_ctl_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [N-1:0] sync_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[N-2:0], d_i};
  end
  assign q_o = sync_q[N-1];
endmodule

// File: rtl/cond_ctl_seq.sv
// cond_ctl_seq: four-phase keep/drop token sequencer; define COND_CTL_ACK_SYNC_EN to synchronize actl_i.
module cond_ctl_seq
  import cond_ctl_pkg::*;
#(
  parameter int W = 8,
  parameter int C = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] div_i,
  output logic         rctl_o,
  output logic         dctl_o,
  input  logic         actl_i,
  output logic [C-1:0] pass_cnt_o,
  output logic [C-1:0] drop_cnt_o,
  output logic         busy_o
);
  state_e       state_q, state_d;
  logic [W-1:0] d_q, d_d, phase_q, phase_d, div_eff, phase_set, phase_inc;
  logic [C-1:0] pass_q, pass_d, drop_q, drop_d;
  logic         dctl_q, dctl_d, rctl_q, rctl_d, ack_s;

`ifdef COND_CTL_ACK_SYNC_EN
  cond_ctl_sync #(.N(SYNC_DEPTH)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (actl_i),
    .q_o (ack_s)
  );
`else
  assign ack_s = actl_i;
`endif

  assign div_eff   = (div_i == '0) ? W'(1) : div_i;
  assign phase_set = (phase_q >= div_eff) ? '0 : phase_q;
  assign phase_inc = phase_q + W'(1);

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    phase_d = phase_q;
    dctl_d  = dctl_q;
    pass_d  = pass_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE:  state_d = (en && !ack_s) ? SETUP : IDLE;
      SETUP: begin
        d_d     = div_eff;
        phase_d = phase_set;
        dctl_d  = (phase_set == '0);
        state_d = REQ;
      end
      REQ:   state_d = ack_s ? REL : REQ;
      REL: begin
        if (!ack_s) begin
          pass_d  = dctl_q ? pass_q + C'(1) : pass_q;
          drop_d  = dctl_q ? drop_q : drop_q + C'(1);
          phase_d = (phase_inc == d_q) ? '0 : phase_inc;
          state_d = en ? SETUP : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // registered request avoids decode glitches on the handshake wire
    rctl_d = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      d_q     <= '0;
      phase_q <= '0;
      dctl_q  <= 1'b0;
      rctl_q  <= 1'b0;
      pass_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      phase_q <= phase_d;
      dctl_q  <= dctl_d;
      rctl_q  <= rctl_d;
      pass_q  <= pass_d;
      drop_q  <= drop_d;
    end
  end

  assign rctl_o     = rctl_q;
  assign dctl_o     = dctl_q;
  assign pass_cnt_o = pass_q;
  assign drop_cnt_o = drop_q;
  assign busy_o     = (state_q != IDLE);
endmodule
